// File: rtl/neural_implant_pkg.sv
// rtl/neural_implant_pkg.sv - Shared ADC front-end widths and scan state encoding.
package neural_implant_pkg;

  localparam int CH_W   = 4;
  localparam int DATA_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    SETTLE,
    CONVERT,
    EMIT
  } scan_state_e;

endpackage

// File: rtl/adc_frame_timer.sv
// rtl/adc_frame_timer.sv - Reload down-counter producing one frame tick every frame_period+1 cycles.
module adc_frame_timer #(
  parameter int FRAME_W = 16
) (
  input  logic               adc_clk,
  input  logic               adc_rst,
  input  logic               enable,
  input  logic [FRAME_W-1:0] frame_period,
  output logic               tick
);

  logic [FRAME_W-1:0] cnt_q;

  // Parked at zero while disabled so the first enabled cycle ticks immediately.
  assign tick = enable && (cnt_q == '0);

  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst) begin
      cnt_q <= '0;
    end else if (!enable) begin
      cnt_q <= '0;
    end else if (cnt_q == '0) begin
      cnt_q <= frame_period;
    end else begin
      cnt_q <= cnt_q - FRAME_W'(1);
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - Walks enabled channels each frame: select, settle, convert, emit.
module adc_scan_sequencer
  import neural_implant_pkg::*;
#(
  parameter int NUM_CH      = 16,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int FRAME_W     = 16
) (
  input  logic               adc_clk,
  input  logic               adc_rst,
  input  logic               enable,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic [FRAME_W-1:0] frame_period,
  input  logic               err_clr,
  output logic [CH_W-1:0]    mux_sel,
  output logic               conv_start,
  input  logic               conv_done,
  input  logic [DATA_W-1:0]  conv_data,
  output logic [DATA_W-1:0]  adc_sample,
  output logic [CH_W-1:0]    adc_channel,
  output logic               adc_valid,
  output logic               frame_start,
  output logic               busy,
  output logic               timeout_err,
  output logic               frame_overrun
);

  localparam int PTR_W = CH_W + 1;
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  scan_state_e        state_q;
  logic [NUM_CH-1:0]  snap_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   ptr_d;
  logic [SET_W-1:0]   settle_cnt_q;
  logic [TO_W-1:0]    to_cnt_q;
  logic [CH_W-1:0]    mux_sel_q;
  logic               conv_start_q;
  logic [DATA_W-1:0]  adc_sample_q;
  logic [CH_W-1:0]    adc_channel_q;
  logic               adc_valid_q;
  logic               frame_start_q;
  logic               busy_q;
  logic               timeout_err_q;
  logic               frame_overrun_q;

  logic               tick;
  logic               pick_found;
  logic [CH_W-1:0]    pick_idx;
  logic               ovr_set;
  logic               to_set;

  adc_frame_timer #(
    .FRAME_W (FRAME_W)
  ) u_frame_timer (
    .adc_clk      (adc_clk),
    .adc_rst      (adc_rst),
    .enable       (enable),
    .frame_period (frame_period),
    .tick         (tick)
  );

  // Lowest snapshot bit at or above the pointer; a pointer of NUM_CH finds nothing.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (snap_q[i] && (PTR_W'(i) >= ptr_q)) begin
        pick_found = 1'b1;
        pick_idx   = CH_W'(i);
      end
    end
  end

  assign ptr_d   = PTR_W'(mux_sel_q) + PTR_W'(1);
  assign ovr_set = tick && (state_q != IDLE);
  assign to_set  = (state_q == CONVERT) && !conv_done &&
                   (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst) begin
      state_q         <= IDLE;
      snap_q          <= '0;
      ptr_q           <= '0;
      settle_cnt_q    <= '0;
      to_cnt_q        <= '0;
      mux_sel_q       <= '0;
      conv_start_q    <= 1'b0;
      adc_sample_q    <= '0;
      adc_channel_q   <= '0;
      adc_valid_q     <= 1'b0;
      frame_start_q   <= 1'b0;
      busy_q          <= 1'b0;
      timeout_err_q   <= 1'b0;
      frame_overrun_q <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      conv_start_q  <= 1'b0;
      adc_valid_q   <= 1'b0;

      // Sticky flags: a new event outranks a clear in the same cycle.
      if (ovr_set) begin
        frame_overrun_q <= 1'b1;
      end else if (err_clr) begin
        frame_overrun_q <= 1'b0;
      end
      if (to_set) begin
        timeout_err_q <= 1'b1;
      end else if (err_clr) begin
        timeout_err_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (tick && (ch_mask != '0)) begin
            snap_q        <= ch_mask;
            ptr_q         <= '0;
            frame_start_q <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= SELECT;
          end
        end

        SELECT: begin
          if (!enable || !pick_found) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            mux_sel_q    <= pick_idx;
            settle_cnt_q <= '0;
            state_q      <= SETTLE;
          end
        end

        SETTLE: begin
          if (!enable) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (settle_cnt_q == SET_W'(SETTLE_CYC - 1)) begin
            conv_start_q <= 1'b1;
            to_cnt_q     <= '0;
            state_q      <= CONVERT;
          end else begin
            settle_cnt_q <= settle_cnt_q + SET_W'(1);
          end
        end

        // A conversion in flight is always allowed to finish so the converter
        // is never left mid-cycle; with enable low its result is dropped.
        CONVERT: begin
          if (conv_done) begin
            ptr_q <= ptr_d;
            if (enable) begin
              adc_valid_q   <= 1'b1;
              adc_sample_q  <= conv_data;
              adc_channel_q <= mux_sel_q;
              state_q       <= EMIT;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
            ptr_q <= ptr_d;
            if (enable) begin
              state_q <= SELECT;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end

        EMIT: begin
          if (!enable) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            state_q <= SELECT;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mux_sel       = mux_sel_q;
  assign conv_start    = conv_start_q;
  assign adc_sample    = adc_sample_q;
  assign adc_channel   = adc_channel_q;
  assign adc_valid     = adc_valid_q;
  assign frame_start   = frame_start_q;
  assign busy          = busy_q;
  assign timeout_err   = timeout_err_q;
  assign frame_overrun = frame_overrun_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb/tb_adc_scan_sequencer.sv - Directed and randomized checks of adc_scan_sequencer against a timing model.
module tb_adc_scan_sequencer;
  import neural_implant_pkg::*;

  localparam int NUM_CH  = 16;
  localparam int SETTLE  = 4;
  localparam int TOUT    = 64;
  localparam int FRAME_W = 16;

  logic               adc_clk = 1'b0;
  logic               adc_rst;
  logic               enable;
  logic [NUM_CH-1:0]  ch_mask;
  logic [FRAME_W-1:0] frame_period;
  logic               err_clr;
  logic [CH_W-1:0]    mux_sel;
  logic               conv_start;
  logic               conv_done;
  logic [DATA_W-1:0]  conv_data;
  logic [DATA_W-1:0]  adc_sample;
  logic [CH_W-1:0]    adc_channel;
  logic               adc_valid;
  logic               frame_start;
  logic               busy;
  logic               timeout_err;
  logic               frame_overrun;

  int cyc     = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int n_beats = 0;
  int n_fs    = 0;

  adc_scan_sequencer dut (
    .adc_clk       (adc_clk),
    .adc_rst       (adc_rst),
    .enable        (enable),
    .ch_mask       (ch_mask),
    .frame_period  (frame_period),
    .err_clr       (err_clr),
    .mux_sel       (mux_sel),
    .conv_start    (conv_start),
    .conv_done     (conv_done),
    .conv_data     (conv_data),
    .adc_sample    (adc_sample),
    .adc_channel   (adc_channel),
    .adc_valid     (adc_valid),
    .frame_start   (frame_start),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .frame_overrun (frame_overrun)
  );

  always #5 adc_clk = ~adc_clk;

  always @(posedge adc_clk) cyc <= cyc + 1;

  always @(negedge adc_clk) begin
    if (adc_valid)   n_beats <= n_beats + 1;
    if (frame_start) n_fs    <= n_fs + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish within 2ms");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_fs(output int fs);
    fs = -1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge adc_clk);
      if (frame_start) begin
        fs = cyc;
        break;
      end
    end
    chk("frame_start_seen", 32'(fs >= 0), 32'd1);
  endtask

  task automatic wait_cs(input string tag, input int exp_cyc);
    for (int k = 0; k < 500; k++) begin
      @(negedge adc_clk);
      if (conv_start) break;
    end
    chk(tag, 32'(cyc), 32'(exp_cyc));
  endtask

  // Called at the negedge of the conv_start cycle; returns at the negedge after conv_done.
  task automatic conv(input int lat, input logic [DATA_W-1:0] d);
    repeat (lat) @(negedge adc_clk);
    conv_done = 1'b1;
    conv_data = d;
    @(negedge adc_clk);
    conv_done = 1'b0;
  endtask

  // Model: channels in ascending mask order; SELECT at s, conv_start at s+1+SETTLE,
  // beat one cycle after conv_done, next SELECT one cycle after the beat,
  // or at conv_start+TOUT on a timeout; IDLE one cycle after the final SELECT.
  task automatic scan_body(input logic [NUM_CH-1:0] mask, input logic [NUM_CH-1:0] nodone,
                           input int lat_fix, input int fs);
    int next_cs, sel, beats0, exp_beats, lat;
    logic [DATA_W-1:0] d;
    logic err0;
    beats0    = n_beats;
    exp_beats = 0;
    sel       = fs;
    next_cs   = fs + 1 + SETTLE;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (mask[ch]) begin
        wait_cs("conv_start_cycle", next_cs);
        chk("mux_sel", 32'(mux_sel), 32'(ch));
        if (nodone[ch]) begin
          err0 = timeout_err;
          repeat (TOUT - 1) @(negedge adc_clk);
          chk("timeout_err_before_limit", 32'(timeout_err), 32'(err0));
          @(negedge adc_clk);
          chk("timeout_err_set", 32'(timeout_err), 32'd1);
          sel = cyc;
        end else begin
          lat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 9));
          d   = DATA_W'($urandom);
          conv(lat, d);
          chk("adc_valid", 32'(adc_valid), 32'd1);
          chk("adc_sample", 32'(adc_sample), 32'(d));
          chk("adc_channel", 32'(adc_channel), 32'(ch));
          exp_beats++;
          sel = cyc + 1;
        end
        next_cs = sel + 1 + SETTLE;
      end
    end
    while (cyc < sel) @(negedge adc_clk);
    chk("busy_last_select", 32'(busy), 32'd1);
    @(negedge adc_clk);
    chk("busy_after_scan", 32'(busy), 32'd0);
    chk("beat_count", 32'(n_beats - beats0), 32'(exp_beats));
  endtask

  task automatic start_frame(input logic [NUM_CH-1:0] m, input int period, output int fs);
    int en;
    enable       = 1'b0;
    ch_mask      = m;
    frame_period = FRAME_W'(period);
    repeat (3) @(negedge adc_clk);
    enable = 1'b1;
    en     = cyc;
    wait_fs(fs);
    chk("tick_to_frame_start", 32'(fs), 32'(en + 1));
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge adc_clk);
    err_clr = 1'b0;
    @(negedge adc_clk);
  endtask

  initial begin
    int fs, fs2, base, cs1;
    logic [NUM_CH-1:0] m, nd;
    logic [DATA_W-1:0] d0, d1;

    adc_rst      = 1'b1;
    enable       = 1'b0;
    ch_mask      = '0;
    frame_period = '0;
    err_clr      = 1'b0;
    conv_done    = 1'b0;
    conv_data    = '0;
    repeat (3) @(negedge adc_clk);
    adc_rst = 1'b0;
    @(negedge adc_clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mux_sel", 32'(mux_sel), 32'd0);
    chk("rst_outputs", 32'({conv_start, adc_valid, frame_start, timeout_err, frame_overrun}), 32'd0);
    chk("rst_sample", 32'({adc_sample, adc_channel}), 32'd0);

    conv_done = 1'b1;
    conv_data = 12'hABC;
    @(negedge adc_clk);
    conv_done = 1'b0;
    @(negedge adc_clk);
    chk("done_in_idle_ignored", 32'(n_beats), 32'd0);

    // Two frames of ch0/ch2 at period 199 with a fixed 3-cycle conversion.
    start_frame(16'h0005, 199, fs);
    scan_body(16'h0005, 16'h0000, 3, fs);
    wait_fs(fs2);
    chk("frame_period_200", 32'(fs2 - fs), 32'd200);
    scan_body(16'h0005, 16'h0000, 3, fs2);

    start_frame(16'h8001, 1500, fs);
    scan_body(16'h8001, 16'h0000, -1, fs);

    // ch3 never completes.
    start_frame(16'h0018, 1500, fs);
    scan_body(16'h0018, 16'h0008, -1, fs);
    chk("timeout_err_sticky", 32'(timeout_err), 32'd1);
    pulse_err_clr();
    chk("timeout_err_cleared", 32'(timeout_err), 32'd0);

    // Frame period far shorter than a full-mask scan.
    base = n_fs;
    start_frame(16'hFFFF, 10, fs);
    scan_body(16'hFFFF, 16'h0000, -1, fs);
    chk("frame_overrun_set", 32'(frame_overrun), 32'd1);
    chk("no_frame_start_while_busy", 32'(n_fs - base), 32'd1);
    enable = 1'b0;
    repeat (6) @(negedge adc_clk);
    pulse_err_clr();
    chk("frame_overrun_cleared", 32'(frame_overrun), 32'd0);

    // enable drops while ch1 is converting.
    base = n_beats;
    start_frame(16'h0003, 1500, fs);
    wait_cs("en_drop_cs0", fs + 1 + SETTLE);
    d0 = DATA_W'($urandom);
    conv(2, d0);
    chk("en_drop_ch0_sample", 32'(adc_sample), 32'(d0));
    cs1 = cyc + 2 + SETTLE;
    wait_cs("en_drop_cs1", cs1);
    enable = 1'b0;
    d1 = ~d0;
    conv(5, d1);
    chk("en_drop_no_valid", 32'(adc_valid), 32'd0);
    chk("en_drop_idle", 32'(busy), 32'd0);
    chk("en_drop_sample_held", 32'(adc_sample), 32'(d0));
    @(negedge adc_clk);
    chk("en_drop_beats", 32'(n_beats - base), 32'd1);

    // Mask rewritten right after the frame started.
    start_frame(16'h0011, 1500, fs);
    ch_mask = 16'h0002;
    scan_body(16'h0011, 16'h0000, -1, fs);
    enable = 1'b0;

    // Reset while settling on ch2.
    start_frame(16'h0004, 1500, fs);
    @(negedge adc_clk);
    chk("settle_mux_sel", 32'(mux_sel), 32'd2);
    @(negedge adc_clk);
    adc_rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_mux_sel", 32'(mux_sel), 32'd0);
    chk("midrst_sample", 32'({adc_sample, adc_channel}), 32'd0);
    chk("midrst_pulses", 32'({conv_start, adc_valid, frame_start, timeout_err, frame_overrun}), 32'd0);
    enable = 1'b0;
    @(negedge adc_clk);
    adc_rst = 1'b0;
    repeat (SETTLE + 2) @(negedge adc_clk);
    chk("postrst_no_conv_start", 32'(conv_start), 32'd0);

    // Randomized masks, latencies and occasional dead channels.
    for (int r = 0; r < 6; r++) begin
      m  = NUM_CH'($urandom_range(1, 65535));
      nd = (r % 2 == 1) ? (m & NUM_CH'($urandom) & NUM_CH'($urandom) & NUM_CH'($urandom)) : '0;
      start_frame(m, 1500, fs);
      scan_body(m, nd, -1, fs);
      enable = 1'b0;
      pulse_err_clr();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
